// File: rtl/reconf_fir_filter.sv
// 12-tap reconfigurable FIR: run-time coefficient banks for positive/negative taps, windowed accumulate.
// Optional FIR_SATURATE_EN: clamp the 25-bit difference to 16 bits instead of wrapping.
module reconf_fir_filter (
    input  logic        iClk_12M,
    input  logic        iRsn,
    input  logic        iEnSample_600k,
    input  logic        iCoeffiUpdateFlag,
    input  logic        iCsnRam,
    input  logic        iWrnRam,
    input  logic [3:0]  iAddrRam_pos,
    input  logic [3:0]  iAddrRam_neg,
    input  logic [15:0] iWrDtRam,
    input  logic [5:0]  iNumOfCoeff,
    input  logic [2:0]  iFirIn,
    output logic [15:0] oFirOut
);

    localparam int unsigned NTAP = 12;
    localparam int unsigned BANK = 16;
    localparam int unsigned CW   = 16;
    localparam int unsigned DW   = 3;
    localparam int unsigned PW   = 19;
    localparam int unsigned AW   = 24;
    localparam int unsigned RW   = 25;

    typedef enum logic [1:0] {p_Idle, p_SpSram, p_Acc, p_Sum} state_e;

    state_e                state_q;
    logic [1:0]            csn_run_q;
    logic signed [DW-1:0]  tap_q      [NTAP];
    logic signed [CW-1:0]  pos_bank_q [BANK];
    logic signed [CW-1:0]  neg_bank_q [BANK];

    logic                  rd_pos_vld_q, rd_neg_vld_q;
    logic signed [CW-1:0]  rd_pos_coef_q, rd_neg_coef_q;
    logic [3:0]            rd_pos_tap_q, rd_neg_tap_q;

    logic signed [AW-1:0]  acc_pos_q, acc_pos_d;
    logic signed [AW-1:0]  acc_neg_q, acc_neg_d;

    logic                  wr_en_c, rd_en_c, acc_clr_c;
    logic [5:0]            num_eff_c;
    logic signed [DW-1:0]  tap_pos_c, tap_neg_c;
    logic signed [PW-1:0]  prod_pos_c, prod_neg_c;
    logic signed [RW-1:0]  diff_c;
    logic [CW-1:0]         result_c;

    // Positive bank: 1..6 -> odd taps 1..11, 7 -> tap 12; anything else never contributes.
    function automatic logic [3:0] map_pos(input logic [3:0] a);
        if (a >= 4'd1 && a <= 4'd6) return 4'({a, 1'b0} - 5'd1);
        else if (a == 4'd7)         return 4'd12;
        else                        return 4'd0;
    endfunction

    // Negative bank: 1..5 -> even taps 2..10.
    function automatic logic [3:0] map_neg(input logic [3:0] b);
        if (b >= 4'd1 && b <= 4'd5) return 4'({b, 1'b0});
        else                        return 4'd0;
    endfunction

    assign wr_en_c   = (state_q == p_SpSram) && !iCsnRam && !iWrnRam;
    assign rd_en_c   = (state_q == p_Acc) && !iCsnRam && iWrnRam && !iCoeffiUpdateFlag;
    assign acc_clr_c = (state_q == p_Acc) && iEnSample_600k;
    assign num_eff_c = (iNumOfCoeff > 6'd12) ? 6'd12 : iNumOfCoeff;

    // Delay line shifts on every strobe, independent of state.
    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            for (int i = 0; i < int'(NTAP); i++) tap_q[i] <= '0;
        end else if (iEnSample_600k) begin
            tap_q[0] <= $signed(iFirIn);
            for (int i = 1; i < int'(NTAP); i++) tap_q[i] <= tap_q[i-1];
        end
    end

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            for (int i = 0; i < int'(BANK); i++) begin
                pos_bank_q[i] <= '0;
                neg_bank_q[i] <= '0;
            end
        end else if (wr_en_c) begin
            if (iAddrRam_pos != 4'd0) pos_bank_q[iAddrRam_pos] <= $signed(iWrDtRam);
            if (iAddrRam_neg != 4'd0) neg_bank_q[iAddrRam_neg] <= $signed(iWrDtRam);
        end
    end

    // Synchronous bank read; the mapped tap index travels with the data.
    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            rd_pos_vld_q  <= 1'b0;
            rd_neg_vld_q  <= 1'b0;
            rd_pos_coef_q <= '0;
            rd_neg_coef_q <= '0;
            rd_pos_tap_q  <= '0;
            rd_neg_tap_q  <= '0;
        end else begin
            rd_pos_vld_q  <= rd_en_c && (iAddrRam_pos != 4'd0);
            rd_neg_vld_q  <= rd_en_c && (iAddrRam_neg != 4'd0);
            rd_pos_coef_q <= pos_bank_q[iAddrRam_pos];
            rd_neg_coef_q <= neg_bank_q[iAddrRam_neg];
            rd_pos_tap_q  <= map_pos(iAddrRam_pos);
            rd_neg_tap_q  <= map_neg(iAddrRam_neg);
        end
    end

    // Taps beyond the active count select zero.
    always_comb begin
        tap_pos_c = '0;
        tap_neg_c = '0;
        for (int i = 0; i < int'(NTAP); i++) begin
            if (rd_pos_tap_q == 4'(i + 1) && 6'(i + 1) <= num_eff_c) tap_pos_c = tap_q[i];
            if (rd_neg_tap_q == 4'(i + 1) && 6'(i + 1) <= num_eff_c) tap_neg_c = tap_q[i];
        end
    end

    assign prod_pos_c = PW'(rd_pos_coef_q) * PW'(tap_pos_c);
    assign prod_neg_c = PW'(rd_neg_coef_q) * PW'(tap_neg_c);

    always_comb begin
        acc_pos_d = acc_clr_c ? '0 : acc_pos_q;
        acc_neg_d = acc_clr_c ? '0 : acc_neg_q;
        if (rd_pos_vld_q) acc_pos_d = acc_pos_d + AW'(prod_pos_c);
        if (rd_neg_vld_q) acc_neg_d = acc_neg_d + AW'(prod_neg_c);
        if (state_q == p_Sum || iCoeffiUpdateFlag) begin
            acc_pos_d = '0;
            acc_neg_d = '0;
        end
    end

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            acc_pos_q <= '0;
            acc_neg_q <= '0;
        end else begin
            acc_pos_q <= acc_pos_d;
            acc_neg_q <= acc_neg_d;
        end
    end

    assign diff_c = RW'(acc_pos_q) - RW'(acc_neg_q);

`ifdef FIR_SATURATE_EN
    always_comb begin
        if (diff_c > 25'sd32767)       result_c = 16'h7FFF;
        else if (diff_c < -25'sd32768) result_c = 16'h8000;
        else                           result_c = diff_c[CW-1:0];
    end
`else
    logic unused_hi_c;
    assign result_c    = diff_c[CW-1:0];
    assign unused_hi_c = ^diff_c[RW-1:CW];
`endif

    // Run length of iCsnRam high, saturating at 2, so only the second high cycle ends a window.
    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn)         csn_run_q <= 2'd0;
        else if (!iCsnRam) csn_run_q <= 2'd0;
        else if (csn_run_q != 2'd2) csn_run_q <= csn_run_q + 2'd1;
    end

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            state_q <= p_Idle;
            oFirOut <= '0;
        end else if (iCoeffiUpdateFlag) begin
            state_q <= p_SpSram;
        end else begin
            case (state_q)
                p_Idle:   state_q <= p_Idle;
                p_SpSram: state_q <= p_Acc;
                p_Acc:    if (iCsnRam && csn_run_q == 2'd1) state_q <= p_Sum;
                p_Sum: begin
                    oFirOut <= result_c;
                    state_q <= p_Acc;
                end
                default:  state_q <= p_Idle;
            endcase
        end
    end

endmodule

// File: tb/tb_reconf_fir_filter.sv
// Scoreboard bench for reconf_fir_filter: stimulus pushes expected outputs, a monitor compares at due cycles.
module tb_reconf_fir_filter;

    logic        clk;
    logic        rst_n;
    logic        strobe;
    logic        upd;
    logic        csn;
    logic        wrn;
    logic [3:0]  apos;
    logic [3:0]  aneg;
    logic [15:0] wdat;
    logic [5:0]  num;
    logic [2:0]  fir_in;
    logic [15:0] fir_out;

    reconf_fir_filter dut (
        .iClk_12M          (clk),
        .iRsn              (rst_n),
        .iEnSample_600k    (strobe),
        .iCoeffiUpdateFlag (upd),
        .iCsnRam           (csn),
        .iWrnRam           (wrn),
        .iAddrRam_pos      (apos),
        .iAddrRam_neg      (aneg),
        .iWrDtRam          (wdat),
        .iNumOfCoeff       (num),
        .iFirIn            (fir_in),
        .oFirOut           (fir_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] val;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference state: coefficient banks as signed ints, delay line newest-first.
    int m_pos[16];
    int m_neg[16];
    int m_tap[12];

    int imp_tbl[13] = '{3, -6, 7, -11, 13, -19, 24, -37, 48, -102, 206, 500, 0};
    int pv[7]       = '{3, 7, 13, 24, 48, 206, 500};
    int nv[5]       = '{6, 11, 19, 37, 102};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] model_out(input int n);
        int ne;
        int s;
        ne = (n > 12) ? 12 : n;
        s  = 0;
        for (int a = 1; a <= 6; a++) if (2*a - 1 <= ne) s += m_pos[a] * m_tap[2*a - 2];
        if (ne >= 12) s += m_pos[7] * m_tap[11];
        for (int b = 1; b <= 5; b++) if (2*b <= ne) s -= m_neg[b] * m_tap[2*b - 1];
`ifdef FIR_SATURATE_EN
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
`endif
        return 16'(s);
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (fir_out !== e.val || e.due != cyc) begin
                    errors++;
                    $display("FAIL out id=%0d cyc=%0d got %0d want %0d",
                             e.id, cyc, $signed(fir_out), $signed(e.val));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        strobe = 1'b0;
        csn    = 1'b1;
        wrn    = 1'b1;
        apos   = 4'd0;
        aneg   = 4'd0;
        wdat   = 16'd0;
    endtask

    task automatic push(input int due, input logic [15:0] v, input int id);
        exp_t e;
        e.due = due;
        e.val = v;
        e.id  = id;
        sb.push_back(e);
    endtask

    task automatic shift_model(input logic [2:0] x);
        for (int i = 11; i > 0; i--) m_tap[i] = m_tap[i-1];
        m_tap[0] = int'($signed(x));
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) begin
            m_pos[i] = 0;
            m_neg[i] = 0;
        end
        for (int i = 0; i < 12; i++) m_tap[i] = 0;
    endtask

    // One 20-clock sample period: strobe, 7 read cycles, then iCsnRam high to close the window.
    task automatic sample(input logic [2:0] x, input int n, input bit use_lit, input int lit, input int id);
        for (int c = 0; c < 20; c++) begin
            step();
            bus_idle();
            if (c == 0) begin
                strobe = 1'b1;
                fir_in = x;
                num    = 6'(n);
                shift_model(x);
                push(cyc + 15, use_lit ? 16'(lit) : model_out(n), id);
            end else if (c <= 7) begin
                csn  = 1'b0;
                wrn  = 1'b1;
                apos = 4'(c);
                aneg = (c <= 5) ? 4'(c) : 4'd0;
            end
        end
    endtask

    task automatic begin_load();
        step();
        bus_idle();
        upd = 1'b1;
    endtask

    task automatic wr(input int pa, input int na, input logic [15:0] d);
        step();
        bus_idle();
        csn  = 1'b0;
        wrn  = 1'b0;
        apos = 4'(pa);
        aneg = 4'(na);
        wdat = d;
        if (pa != 0) m_pos[pa] = int'($signed(d));
        if (na != 0) m_neg[na] = int'($signed(d));
    endtask

    task automatic end_load();
        step();
        bus_idle();
        step();
        upd = 1'b0;
    endtask

    task automatic strobe_in_load(input logic [2:0] x);
        step();
        bus_idle();
        strobe = 1'b1;
        fir_in = x;
        shift_model(x);
    endtask

    task automatic load_std();
        begin_load();
        for (int a = 1; a <= 7; a++) wr(a, 0, 16'(pv[a-1]));
        for (int b = 1; b <= 5; b++) wr(0, b, 16'(nv[b-1]));
        wr(0, 0, 16'h1234);
        wr(9, 7, 16'h1234);
        end_load();
    endtask

    // Reset lands in the middle of the read window; output must drop to 0 and stay there.
    task automatic reset_mid(input int id);
        for (int c = 0; c < 20; c++) begin
            step();
            bus_idle();
            if (c == 0) begin
                strobe = 1'b1;
                fir_in = 3'd2;
                shift_model(3'd2);
            end else if (c <= 3) begin
                csn  = 1'b0;
                apos = 4'(c);
                aneg = 4'(c);
            end else if (c == 4) begin
                rst_n = 1'b0;
                clear_model();
                push(cyc, 16'd0, id);
            end else if (c == 5) begin
                push(cyc, 16'd0, id + 1);
            end else if (c == 6) begin
                rst_n = 1'b1;
            end else if (c == 15) begin
                push(cyc, 16'd0, id + 2);
            end
        end
    endtask

    initial begin
        int sat_lit;
        int n;
`ifdef FIR_SATURATE_EN
        sat_lit = 32767;
`else
        sat_lit = 32'h7FEB;
`endif
        rst_n  = 1'b0;
        upd    = 1'b0;
        num    = 6'd12;
        fir_in = 3'd0;
        bus_idle();
        clear_model();
        step();
        push(cyc, 16'd0, 0);
        step();
        step();
        checks++;
        if (fir_out !== 16'd0) begin
            errors++;
            $display("FAIL reset value got %0d want 0", $signed(fir_out));
        end
        rst_n = 1'b1;

        load_std();
        checks++;
        if (fir_out !== 16'd0) begin
            errors++;
            $display("FAIL output after load got %0d want 0", $signed(fir_out));
        end
        sample(3'd1, 12, 1'b1, imp_tbl[0], 100);
        for (int i = 1; i < 13; i++) sample(3'd0, 12, 1'b1, imp_tbl[i], 100 + i);

        sample(3'b100, 12, 1'b0, 0, 200);
        for (int i = 1; i < 13; i++) sample(3'd0, 12, 1'b0, 0, 200 + i);

        sample(3'd1, 6, 1'b0, 0, 300);
        for (int i = 1; i < 13; i++) sample(3'd0, 6, 1'b0, 0, 300 + i);

        begin_load();
        wr(3, 0, 16'd13);
        strobe_in_load(3'd1);
        end_load();
        for (int i = 0; i < 12; i++) sample(3'd0, 12, 1'b0, 0, 320 + i);

        for (int r = 0; r < 3; r++) begin
            begin_load();
            for (int a = 1; a < 16; a++) wr(a, 0, 16'($urandom));
            for (int b = 1; b < 16; b++) wr(0, b, 16'($urandom));
            end_load();
            for (int k = 0; k < 20; k++) begin
                n = (k % 4 == 0) ? int'($urandom_range(13, 63)) : int'($urandom_range(0, 12));
                sample(3'($urandom), n, 1'b0, 0, 1000 + 100*r + k);
            end
        end

        begin_load();
        for (int a = 1; a < 16; a++) wr(a, 0, 16'h7FFF);
        for (int b = 1; b < 16; b++) wr(0, b, 16'h0000);
        end_load();
        for (int i = 0; i < 12; i++) sample(3'd3, 12, 1'b0, 0, 400 + i);
        for (int i = 0; i < 12; i++) sample(3'd3, 12, 1'b0, 0, 420 + i);
        sample(3'd3, 12, 1'b1, sat_lit, 440);

        begin_load();
        for (int a = 1; a < 16; a++) wr(a, 0, 16'h0000);
        for (int b = 1; b < 16; b++) wr(0, b, 16'h7FFF);
        end_load();
        for (int i = 0; i < 14; i++) sample(3'd3, 12, 1'b0, 0, 500 + i);

        load_std();
        sample(3'd1, 12, 1'b0, 0, 600);
        sample(3'd0, 12, 1'b0, 0, 601);
        reset_mid(610);
        checks++;
        if (fir_out !== 16'd0) begin
            errors++;
            $display("FAIL output after mid-window reset got %0d want 0", $signed(fir_out));
        end
        load_std();
        sample(3'd1, 12, 1'b1, imp_tbl[0], 620);
        for (int i = 1; i < 4; i++) sample(3'd0, 12, 1'b1, imp_tbl[i], 620 + i);

        repeat (20) step();
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL pending id=%0d never compared, want %0d", e.id, $signed(e.val));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        if (errors != 0) $display("TEST FAILED");
        else             $display("TEST PASSED");
        $finish;
    end

endmodule

// File: doc/reconf_fir_filter.md
# reconf_fir_filter

Reconfigurable 12-tap FIR filter (Kaiser-windowed coefficient set) running on the 12 MHz system clock with a 600 kHz sample strobe. Coefficients are written at run time into two 16-entry coefficient banks, one for positive taps and one for negative taps. Each sample period an externally sequenced read/accumulate window produces one 16-bit filtered output. The block sits between the 3-bit signed sample source and the downstream 16-bit data path.

## Interface
- No parameters.
- iClk_12M  in  1  system clock, 12 MHz; all logic on its rising edge.
- iRsn  in  1  reset, asynchronous, active-low.
- iEnSample_600k  in  1  one-cycle sample strobe, once every 20 clocks.
- iCoeffiUpdateFlag  in  1  high = coefficient update mode.
- iCsnRam  in  1  bank chip select, active-low.
- iWrnRam  in  1  0 = write, 1 = read.
- iAddrRam_pos  in  4  positive-bank address; 0 = no access.
- iAddrRam_neg  in  4  negative-bank address; 0 = no access.
- iWrDtRam  in  16  coefficient write data, magnitude, signed 16-bit.
- iNumOfCoeff  in  6  active tap count, 1..12.
- iFirIn  in  3  signed input sample, -4..3.
- oFirOut  out  16  signed filter output, registered.

## Operation
- Delay line: 12 × 3-bit registers, tap1..tap12. On iEnSample_600k, tap1 <= iFirIn and tapN <= tapN-1.
- Tap mapping, fixed:
  - Positive bank address a = 1..6 maps to tap 2a-1.
  - Positive bank address 7 maps to tap 12.
  - Negative bank address b = 1..5 maps to tap 2b.
  - Positive addresses 8..15 and negative addresses 6..15 are stored but never contribute.
- Writes occur when iCsnRam=0, iWrnRam=0 and state is p_SpSram.
  - iWrDtRam is written to the positive bank at iAddrRam_pos if nonzero.
  - In the same cycle it is written to the negative bank at iAddrRam_neg if nonzero.
- Reads occur when iCsnRam=0, iWrnRam=1 and state is p_Acc.
  - Each nonzero address is a synchronous read.
  - The next cycle adds coeff × mapped tap to accPos (positive bank) or accNeg (negative bank).
- A tap with index > iNumOfCoeff contributes 0. iNumOfCoeff > 12 is treated as 12. iNumOfCoeff = 0 makes all contributions 0.
- Arithmetic:
  - Product = signed 16 × signed 3 = 19 bits.
  - accPos and accNeg are 24-bit signed.
  - Result = accPos − accNeg, 25-bit, reduced to 16 bits as described under Configuration.
- FSM states: p_Idle, p_SpSram, p_Acc, p_Sum.
  - p_Idle → p_SpSram when iCoeffiUpdateFlag=1.
  - p_SpSram → p_Acc when iCoeffiUpdateFlag=0.
  - p_Acc → p_Sum on the second consecutive cycle with iCsnRam=1 (flushes the read pipeline).
  - p_Sum: oFirOut <= result, accumulators cleared, → p_Acc next cycle.
  - iCoeffiUpdateFlag=1 in any state → p_SpSram with accumulators cleared; oFirOut is held.
- Accumulators also clear on iEnSample_600k while in p_Acc, unless an accumulate occurs in the same cycle, in which case that product becomes the new value.

## Timing
- Reset values:
  - oFirOut = 0.
  - Delay line, accPos, accNeg = 0.
  - All 32 bank entries = 0.
  - State = p_Idle.
  - Reset is honored mid-window; the partial result is discarded.
- Write latency: 1 cycle; data is readable on the next cycle.
- Read-to-accumulate: address in cycle n, data in n+1, accumulated at end of n+1.
- Output latency: oFirOut updates at the end of p_Sum, i.e. 2 cycles after iCsnRam first rises. It is held until the next p_Sum.
- A read and a write to the same address in the same cycle cannot occur, because reads and writes are mode-exclusive.
- Sample strobe during p_SpSram still shifts the delay line.

## Configuration
- FIR_SATURATE_EN defined: the result saturates to the range −32768..32767.
- FIR_SATURATE_EN undefined: the result is truncated to its low 16 bits (two's-complement wrap).

## Test plan
- Load the coefficient set:
  - Positive bank addresses 1..7 = 3, 7, 13, 24, 48, 206, 500.
  - Negative bank addresses 1..5 = 6, 11, 19, 37, 102.
  - Set iNumOfCoeff = 12 and apply a single iFirIn = 1 impulse.
  - Required: successive outputs +3, −6, +7, −11, +13, −19, +24, −37, +48, −102, +206, +500, then 0.
- Same coefficient set, impulse iFirIn = −4 → outputs −12, +24, −28, +44, …, −2000, then 0.
- iNumOfCoeff = 6 with the impulse of 1 → +3, −6, +7, −11, +13, −19, then 0 for taps 7..12.
- Saturation case:
  - Set all positive entries to 0x7FFF, negative entries to 0, and hold iFirIn = 3 for 12 samples.
  - With FIR_SATURATE_EN defined → 32767.
  - Without it → low 16 bits of 688107 (0x7FEB).
- Address 0 write with data 0x1234 → no bank change; the impulse response is unchanged.
- Assert iRsn mid accumulate window → oFirOut = 0 and state p_Idle immediately; the next output reflects only new samples.
